barrel_shift_right_32: RTL and testbench



---
 rtl/shift_pkg.sv | 15 +
 rtl/shift_right_stage.sv | 20 ++
 rtl/barrel_shift_right_32.sv | 46 ++++
 tb/tb_barrel_shift_right_32.sv | 120 ++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and sizes for the 32-bit logical right barrel shifter.
// Pure declarations: no logic, no latency.
// Imported by the shift stages and the top level.
package shift_pkg;

  // Data path width; the shifter is built for exactly this width.
  localparam int SHIFT_WIDTH = 32;

  // Shift amount width, clog2(SHIFT_WIDTH).
  localparam int SHIFT_AMT_W = 5;

  // One data word flowing through the mux network.
  typedef logic [31:0] word_t;

endpackage : shift_pkg

// File: rtl/shift_right_stage.sv
// One level of the logarithmic shifter: shift right by STEP or pass through.
// Purely combinational, zero latency.
// No handshake; output follows inputs continuously.
module shift_right_stage
  import shift_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic [31:0] din,
  input  logic        en,
  output logic [31:0] dout
);

  // Vacated MSBs are zero filled, so this is a logical (not arithmetic) shift.
  logic [31:0] w_shifted;

  assign w_shifted = {{STEP{1'b0}}, din[SHIFT_WIDTH-1:STEP]};
  assign dout      = en ? w_shifted : din;

endmodule : shift_right_stage

// File: rtl/barrel_shift_right_32.sv
// 32-bit logical right barrel shifter, result registered on o_y.
// Latency: one clock from input sample to o_y.
// No handshake: a new operation is accepted every cycle; o_y holds between edges.
module barrel_shift_right_32
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [SHAMT_W-1:0] num_right_i,
  output logic [WIDTH-1:0]   o_y
);

  // w_stage[0] is the raw input; w_stage[k+1] is the output of level k.
  word_t w_stage [0:SHIFT_AMT_W];
  word_t r_y;

  assign w_stage[0] = i_a;

  // Levels shift by 1, 2, 4, 8, 16, each enabled by its own shift-amount bit,
  // so any amount 0..31 is composed in a single pass.
  for (genvar k = 0; k < SHIFT_AMT_W; k++) begin : g_level
    shift_right_stage #(
      .STEP (1 << k)
    ) u_stage (
      .din  (w_stage[k]),
      .en   (num_right_i[k]),
      .dout (w_stage[k+1])
    );
  end

  // Result register; synchronous reset wins over a shift issued in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_y <= '0;
    end else begin
      r_y <= w_stage[SHIFT_AMT_W];
    end
  end

  assign o_y = r_y;

endmodule : barrel_shift_right_32

// File: tb/tb_barrel_shift_right_32.sv
// Scoreboard bench for barrel_shift_right_32: the driver pushes expected results,
// an independent monitor pops and compares one cycle after each issued operation.
// Directed vectors use hand-computed values; the sweep uses a plain >> reference.
module tb_barrel_shift_right_32;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_entry_t;

  logic        clk_i;
  logic        rst_i;
  logic [31:0] i_a;
  logic [4:0]  num_right_i;
  logic [31:0] o_y;

  sb_entry_t sb_q [$];
  int        n_checks;
  int        n_fails;
  bit        drive_done;

  barrel_shift_right_32 #(
    .WIDTH   (32),
    .SHAMT_W (5)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_a         (i_a),
    .num_right_i (num_right_i),
    .o_y         (o_y)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Apply one operation for the next rising edge and record what o_y must become.
  task automatic issue(input logic rst, input logic [31:0] a, input logic [4:0] n,
                       input logic [31:0] exp, input string nm);
    sb_entry_t e;
    @(negedge clk_i);
    rst_i       = rst;
    i_a         = a;
    num_right_i = n;
    e.exp       = exp;
    e.name      = nm;
    sb_q.push_back(e);
  endtask

  // Monitor: after every edge that captured an issued operation, compare o_y.
  always @(posedge clk_i) begin
    sb_entry_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if (o_y !== e.exp) begin
        n_fails++;
        $display("FAIL %s: o_y=%08h expected %08h", e.name, o_y, e.exp);
      end
    end
  end

  initial begin
    logic [31:0] a;
    n_checks    = 0;
    n_fails     = 0;
    drive_done  = 1'b0;
    rst_i       = 1'b1;
    i_a         = 32'h0;
    num_right_i = 5'd0;

    // Reset held for two edges with live-looking inputs.
    issue(1'b1, 32'hF0F0_F0F0, 5'd4, 32'h0000_0000, "reset_edge1");
    issue(1'b1, 32'hF0F0_F0F0, 5'd4, 32'h0000_0000, "reset_edge2");

    // Basic shifts.
    issue(1'b0, 32'hF0F0_F0F0, 5'd0, 32'hF0F0_F0F0, "shift0");
    issue(1'b0, 32'hF0F0_F0F0, 5'd1, 32'h7878_7878, "shift1");
    issue(1'b0, 32'hF0F0_F0F0, 5'd4, 32'h0F0F_0F0F, "shift4");

    // Back-to-back, MSB only.
    issue(1'b0, 32'h8000_0000, 5'd16, 32'h0000_8000, "msb_shift16");
    issue(1'b0, 32'h8000_0000, 5'd31, 32'h0000_0001, "msb_shift31");

    // Zero fill, no sign extension.
    issue(1'b0, 32'hFFFF_FFFF, 5'd8,  32'h00FF_FFFF, "zero_fill8");
    issue(1'b0, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, "zero_fill31");

    // Reset in the middle of a stream, then recovery.
    issue(1'b0, 32'hF0F0_F0F0, 5'd4,  32'h0F0F_0F0F, "pre_reset");
    issue(1'b1, 32'hF0F0_F0F0, 5'd4,  32'h0000_0000, "mid_reset");
    issue(1'b0, 32'h1234_5678, 5'd12, 32'h0001_2345, "post_reset12");

    // Single-level and mixed amounts on a recognisable pattern.
    issue(1'b0, 32'hDEAD_BEEF, 5'd2,  32'h37AB_6FBB, "dead_shift2");
    issue(1'b0, 32'hDEAD_BEEF, 5'd21, 32'h0000_06F5, "dead_shift21");

    // Sweep every amount with random data.
    for (int n = 0; n < 32; n++) begin
      a = $urandom;
      issue(1'b0, a, n[4:0], a >> n, $sformatf("sweep_n%0d", n));
    end

    // Hold inputs quiet so the last result is observed.
    @(negedge clk_i);
    drive_done = 1'b1;

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk_i);
    #2;
    if (sb_q.size() > 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL drain: %0d results not observed, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_barrel_shift_right_32
